// File: rtl/tick_sched.sv
// rtl/tick_sched.sv - round-robin one-hot strobe scheduler with burst and continuous modes
// Define TICK_SCHED_HOLD_EN to add the pi_hold freeze input.
module tick_sched #(
  parameter int PRE_DIV = 1000,
  parameter int PRE_W   = 16,
  parameter int CH_N    = 4,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pi_start,
  input  logic               pi_stop,
  input  logic [BURST_W-1:0] pi_burst,
`ifdef TICK_SCHED_HOLD_EN
  input  logic               pi_hold,
`endif
  output logic [CH_N-1:0]    po_flag,
  output logic               po_busy,
  output logic               po_done,
  output logic [BURST_W-1:0] po_round
);
  localparam int IDX_W = (CH_N > 1) ? $clog2(CH_N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] round_q, round_d;
  logic [CH_N-1:0]    flag_q, flag_d;
  logic               hold, wrap, fin, start_ok, idx_last;

`ifdef TICK_SCHED_HOLD_EN
  assign hold = pi_hold;
`else
  assign hold = 1'b0;
`endif

  assign start_ok = pi_start & ~pi_stop;
  assign wrap     = (state_q == RUN) && !pi_stop && !hold && (pre_q == PRE_W'(PRE_DIV - 1));
  // Final round already counted: the next wrap ends the burst instead of strobing.
  assign fin      = (burst_q != '0) && (round_q == burst_q);
  assign idx_last = (idx_q == IDX_W'(CH_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      idx_q   <= '0;
      burst_q <= '0;
      round_q <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      burst_q <= burst_d;
      round_q <= round_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN: begin
        if (pi_stop)          state_d = IDLE;
        else if (wrap && fin) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_d   = pre_q;
    idx_d   = idx_q;
    burst_d = burst_q;
    round_d = round_q;
    flag_d  = '0;
    case (state_q)
      IDLE: begin
        pre_d = '0;
        if (start_ok) begin
          burst_d = pi_burst;
          idx_d   = '0;
          round_d = '0;
        end
      end
      RUN: begin
        if (pi_stop) begin
          pre_d = '0;
        end else if (!hold) begin
          pre_d = wrap ? '0 : pre_q + 1'b1;
          if (wrap && !fin) begin
            flag_d = CH_N'(1) << idx_q;
            idx_d  = idx_last ? '0 : idx_q + 1'b1;
            if (idx_last) round_d = round_q + 1'b1;
          end
        end
      end
      default: pre_d = '0;
    endcase
  end

  always_comb begin
    po_flag  = flag_q;
    po_busy  = (state_q == RUN);
    po_done  = (state_q == DONE);
    po_round = round_q;
  end
endmodule

// File: tb/tb_tick_sched.sv
// tb/tb_tick_sched.sv - scoreboard bench for tick_sched with a cycle-level event model
module tb_tick_sched;
  localparam int PRE_DIV = 4;
  localparam int CH_N    = 3;
  localparam int BURST_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               pi_start = 1'b0;
  logic               pi_stop = 1'b0;
  logic [BURST_W-1:0] pi_burst = '0;
`ifdef TICK_SCHED_HOLD_EN
  logic               pi_hold = 1'b0;
`endif
  logic [CH_N-1:0]    po_flag;
  logic               po_busy;
  logic               po_done;
  logic [BURST_W-1:0] po_round;

  tick_sched #(.PRE_DIV(PRE_DIV), .PRE_W(16), .CH_N(CH_N), .BURST_W(BURST_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pi_start (pi_start),
    .pi_stop  (pi_stop),
    .pi_burst (pi_burst),
`ifdef TICK_SCHED_HOLD_EN
    .pi_hold  (pi_hold),
`endif
    .po_flag  (po_flag),
    .po_busy  (po_busy),
    .po_done  (po_done),
    .po_round (po_round)
  );

  typedef struct {
    int                 cyc;
    logic [CH_N-1:0]    flag;
    logic               done;
    logic               busy;
    logic [BURST_W-1:0] round;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  // Monitor: every visible strobe or done pulse must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (po_flag != '0 || po_done)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got cyc=%0d flag=%b done=%0b, required no event", cyc, po_flag, po_done);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || po_flag !== e.flag || po_done !== e.done || po_busy !== e.busy || po_round !== e.round) begin
          n_bad++;
          $display("FAIL event: got cyc=%0d flag=%b done=%0b busy=%0b round=%0d, required cyc=%0d flag=%b done=%0b busy=%0b round=%0d",
                   cyc, po_flag, po_done, po_busy, po_round, e.cyc, e.flag, e.done, e.busy, e.round);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Strobe k lands PRE_DIV*(k+1) edges after start; hold edges push later events out; stop cuts the list.
  task automatic push_model(input int t, input int b, input int stop_e, input int h_at, input int h_len,
                            output int fr);
    int n;
    int ec;
    ev_t e;
    n  = (b == 0) ? 200 : b * CH_N;
    fr = 0;
    for (int k = 0; k <= n; k++) begin
      ec = t + PRE_DIV * (k + 1);
      if (h_len > 0 && ec >= h_at) ec += h_len;
      if (stop_e != 0 && ec >= stop_e) break;
      if (k == n && b == 0) break;
      e.cyc = ec;
      if (k < n) begin
        e.flag  = CH_N'(1) << (k % CH_N);
        e.done  = 1'b0;
        e.busy  = 1'b1;
        e.round = BURST_W'((k + 1) / CH_N);
      end else begin
        e.flag  = '0;
        e.done  = 1'b1;
        e.busy  = 1'b0;
        e.round = BURST_W'(b);
      end
      fr = int'(e.round);
      q.push_back(e);
    end
  endtask

  task automatic run_case(input int b, input int stop_off, input int h_off, input int h_len, input bit repulse);
    int t, end_c, fr;
    @(posedge clk); #1;
    t = cyc + 1;
    pi_start = 1'b1;
    pi_burst = BURST_W'(b);
    push_model(t, b, (stop_off != 0) ? t + stop_off : 0, t + h_off, h_len, fr);
    @(posedge clk); #1;
    pi_start = 1'b0;
    pi_burst = BURST_W'($urandom);
    check("busy_after_start", int'(po_busy), 1);
    end_c = (stop_off != 0) ? t + stop_off : t + PRE_DIV * (b * CH_N + 1) + h_len;
    while (cyc < end_c + 2) begin
      @(posedge clk); #1;
      pi_start = repulse && (cyc == t + 5);
      pi_stop  = (stop_off != 0) && (cyc == t + stop_off - 1);
`ifdef TICK_SCHED_HOLD_EN
      pi_hold  = (h_len > 0) && (cyc >= t + h_off - 1) && (cyc < t + h_off - 1 + h_len);
`endif
    end
    pi_start = 1'b0;
    pi_stop  = 1'b0;
    check("pending_events", q.size(), 0);
    check("busy_at_end", int'(po_busy), 0);
    check("round_at_end", int'(po_round), fr);
    q.delete();
  endtask

  initial begin
    int b, s, t, fr;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flag", int'(po_flag), 0);
    check("reset_busy", int'(po_busy), 0);
    check("reset_done", int'(po_done), 0);
    check("reset_round", int'(po_round), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_case(2, 0, 0, 0, 1'b0);
    run_case(2, 0, 0, 0, 1'b1);
    run_case(2, 8, 0, 0, 1'b0);
    run_case(0, PRE_DIV * 48 + 2, 0, 0, 1'b0);

    @(posedge clk); #1;
    pi_start = 1'b1;
    pi_stop  = 1'b1;
    pi_burst = 4'd1;
    @(posedge clk); #1;
    pi_start = 1'b0;
    pi_stop  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("start_stop_idle", int'(po_busy), 0);

    for (int i = 0; i < 6; i++) begin
      b = int'($urandom_range(1, 4));
      s = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, PRE_DIV * (CH_N * b + 1))) : 0;
      run_case(b, s, 0, 0, 1'b0);
    end

`ifdef TICK_SCHED_HOLD_EN
    run_case(1, 0, 6, 10, 1'b0);
`endif

    @(posedge clk); #1;
    t = cyc + 1;
    pi_start = 1'b1;
    pi_burst = 4'd3;
    push_model(t, 3, 0, t, 0, fr);
    @(posedge clk); #1;
    pi_start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("async_rst_flag", int'(po_flag), 0);
    check("async_rst_busy", int'(po_busy), 0);
    check("async_rst_round", int'(po_round), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_busy", int'(po_busy), 0);
    check("post_rst_round", int'(po_round), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
